// File: rtl/wrr_arbiter.sv
// Weighted round-robin arbiter with an urgent priority class. A granted port keeps
// its grant for up to weight[i] bursts; urgent requesters pre-empt only at burst boundaries.
module wrr_arbiter #(
  parameter int PORTS     = 4,
  parameter int WEIGHT_W  = 4,
  parameter bit URGENT_EN = 1'b1
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [PORTS-1:0]            request,
  input  logic [PORTS-1:0]            urgent,
  input  logic [PORTS-1:0]            acknowledge,
  input  logic [PORTS-1:0]            last,
  input  logic [PORTS*WEIGHT_W-1:0]   weight,
  output logic [PORTS-1:0]            grant,
  output logic                        grant_valid,
  output logic [$clog2(PORTS)-1:0]    grant_encoded,
  output logic [WEIGHT_W-1:0]         credit
);

  localparam int IDX_W = $clog2(PORTS);

  typedef enum logic {IDLE = 1'b0, GRANTED = 1'b1} state_t;

  state_t               state_q, state_d;
  logic [PORTS-1:0]     grant_q, grant_d;
  logic [IDX_W-1:0]     enc_q, enc_d;
  logic [IDX_W-1:0]     ptr_q, ptr_d;
  logic [WEIGHT_W-1:0]  credit_q, credit_d;

  logic [WEIGHT_W-1:0]  weight_arr [PORTS];
  logic                 boundary, hold, others_urgent;
  logic [PORTS-1:0]     excl, pool, urgent_pool, cand, rot;
  logic [2*PORTS-1:0]   cand2, rot2;
  logic [IDX_W:0]       shift, sel_sum;
  logic [IDX_W-1:0]     sel_off, sel_idx;
  logic                 sel_found;
  logic [WEIGHT_W-1:0]  sel_weight, sel_quota;

  genvar gi;
  generate
    for (gi = 0; gi < PORTS; gi++) begin : g_weight
      assign weight_arr[gi] = weight[gi*WEIGHT_W +: WEIGHT_W];
    end
  endgenerate

  assign boundary      = (state_q == GRANTED) && (|(grant_q & acknowledge & last));
  assign others_urgent = URGENT_EN && (|(request & urgent & ~grant_q));
  assign hold          = boundary && (credit_q > WEIGHT_W'(1)) && (|(grant_q & request)) &&
                         (!URGENT_EN || (|(grant_q & urgent)) || !others_urgent);

  // The releasing port is removed before the urgent filter, so an exhausted turn
  // always rotates when anyone else is waiting.
  always_comb begin
    excl        = request & ~grant_q;
    pool        = (|excl) ? excl : request;
    urgent_pool = pool & urgent;
    cand        = (URGENT_EN && (|urgent_pool)) ? urgent_pool : pool;
  end

  // Rotate the candidates so bit 0 corresponds to ptr+1, then take the lowest set bit.
  assign cand2 = {cand, cand};
  assign shift = {1'b0, ptr_q} + (IDX_W+1)'(1);
  assign rot2  = cand2 >> shift;
  assign rot   = rot2[PORTS-1:0];

  always_comb begin
    sel_found = 1'b0;
    sel_off   = '0;
    for (int k = PORTS-1; k >= 0; k--) begin
      if (rot[k]) begin
        sel_found = 1'b1;
        sel_off   = IDX_W'(k);
      end
    end
  end

  assign sel_sum    = shift + {1'b0, sel_off};
  assign sel_idx    = (sel_sum >= (IDX_W+1)'(PORTS)) ? IDX_W'(sel_sum - (IDX_W+1)'(PORTS))
                                                     : sel_sum[IDX_W-1:0];
  assign sel_weight = weight_arr[sel_idx];
  assign sel_quota  = (sel_weight == '0) ? WEIGHT_W'(1) : sel_weight;

  always_comb begin
    state_d  = state_q;
    grant_d  = grant_q;
    enc_d    = enc_q;
    ptr_d    = ptr_q;
    credit_d = credit_q;
    if ((state_q == IDLE) || boundary) begin
      if (hold) begin
        credit_d = credit_q - WEIGHT_W'(1);
      end else if (sel_found) begin
        state_d  = GRANTED;
        grant_d  = {{(PORTS-1){1'b0}}, 1'b1} << sel_idx;
        enc_d    = sel_idx;
        ptr_d    = sel_idx;
        credit_d = sel_quota;
      end else begin
        state_d  = IDLE;
        grant_d  = '0;
        credit_d = '0;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      grant_q  <= '0;
      enc_q    <= '0;
      ptr_q    <= IDX_W'(PORTS-1);
      credit_q <= '0;
    end else begin
      state_q  <= state_d;
      grant_q  <= grant_d;
      enc_q    <= enc_d;
      ptr_q    <= ptr_d;
      credit_q <= credit_d;
    end
  end

  assign grant         = grant_q;
  assign grant_valid   = (state_q == GRANTED);
  assign grant_encoded = enc_q;
  assign credit        = credit_q;

endmodule

// File: tb/tb_wrr_arbiter.sv
// Scoreboarded bench for wrr_arbiter: directed scenarios plus random traffic, every
// cycle's expected outputs come from a behavioural turn/credit model.
module tb_wrr_arbiter;
  localparam int P  = 4;
  localparam int WW = 4;
  localparam bit URGENT_EN = 1'b1;

  logic            clk = 1'b0;
  logic            rst;
  logic [P-1:0]    request, urgent, acknowledge, last;
  logic [P*WW-1:0] weight;
  logic [P-1:0]    grant;
  logic            grant_valid;
  logic [1:0]      grant_encoded;
  logic [WW-1:0]   credit;

  always #5 clk = ~clk;

  wrr_arbiter #(.PORTS(P), .WEIGHT_W(WW), .URGENT_EN(URGENT_EN)) dut (
    .clk(clk), .rst(rst), .request(request), .urgent(urgent),
    .acknowledge(acknowledge), .last(last), .weight(weight),
    .grant(grant), .grant_valid(grant_valid), .grant_encoded(grant_encoded),
    .credit(credit)
  );

  typedef struct packed {
    logic [P-1:0]  g;
    logic          v;
    logic [1:0]    e;
    logic [WW-1:0] c;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   passes = 0;
  int   txn = 0;

  // Reference model: who owns the turn, how many bursts it has left, last winner.
  bit m_valid;
  int m_port, m_credit, m_ptr, m_enc;

  task automatic check(input string name, input int act, input int req);
    checks++;
    if (act == req) passes++;
    else $display("FAIL %s: got %0d expected %0d", name, act, req);
  endtask

  task automatic model_reset();
    m_valid = 1'b0; m_port = 0; m_credit = 0; m_ptr = P-1; m_enc = 0;
  endtask

  function automatic int quota(input int i);
    int w = int'(weight[i*WW +: WW]);
    return (w == 0) ? 1 : w;
  endfunction

  function automatic int choose(input logic [P-1:0] pool);
    logic [P-1:0] u    = pool & urgent;
    logic [P-1:0] cnd  = (URGENT_EN && u != 0) ? u : pool;
    for (int k = 1; k <= P; k++)
      if (cnd[(m_ptr + k) % P]) return (m_ptr + k) % P;
    return 0;
  endfunction

  task automatic model_step();
    logic [P-1:0] me, pool;
    bit others_urg;
    int nxt;
    if (m_valid) begin
      if (!(acknowledge[m_port] && last[m_port])) return;
      me = P'(1) << m_port;
      others_urg = ((request & urgent & ~me) != 0);
      if ((m_credit - 1 > 0) && request[m_port] &&
          (!URGENT_EN || urgent[m_port] || !others_urg)) begin
        m_credit = m_credit - 1;
        return;
      end
      pool = request & ~me;
      if (pool == 0) pool = request;
    end else begin
      pool = request;
    end
    if (pool == 0) begin
      m_valid = 1'b0; m_credit = 0;
      return;
    end
    nxt = choose(pool);
    m_valid = 1'b1; m_port = nxt; m_enc = nxt; m_ptr = nxt; m_credit = quota(nxt);
  endtask

  function automatic exp_t model_out();
    exp_t e;
    e.g = m_valid ? (P'(1) << m_port) : '0;
    e.v = m_valid;
    e.e = 2'(m_enc);
    e.c = WW'(m_credit);
    return e;
  endfunction

  // Inputs change on the falling edge; the model predicts the state after the next rising edge.
  task automatic drive(input logic r, input logic [P-1:0] rq, input logic [P-1:0] ug,
                       input logic [P-1:0] ak, input logic [P-1:0] ls, input logic [P*WW-1:0] wt);
    @(negedge clk);
    rst = r; request = rq; urgent = ug; acknowledge = ak; last = ls; weight = wt;
    if (r) model_reset();
    else model_step();
    exp_q.push_back(model_out());
  endtask

  task automatic expect_now(input string nm, input logic [P-1:0] g, input int cr);
    @(posedge clk); #2;
    check({nm, "_grant"}, int'(grant), int'(g));
    check({nm, "_valid"}, int'(grant_valid), int'(g != 0));
    check({nm, "_credit"}, int'(credit), cr);
  endtask

  task automatic do_reset(input logic [P*WW-1:0] wt);
    drive(1'b1, '0, '0, '0, '0, wt);
    drive(1'b1, '0, '0, '0, '0, wt);
    drive(1'b0, '0, '0, '0, '0, wt);
  endtask

  // Monitor: compares the DUT against the oldest queued expectation after every rising edge.
  exp_t mon_e, mon_a;
  initial begin
    forever begin
      @(posedge clk); #1;
      if (exp_q.size() > 0) begin
        mon_e = exp_q.pop_front();
        mon_a = {grant, grant_valid, grant_encoded, credit};
        txn++;
        $display("txn %0d: grant=%b valid=%b enc=%0d credit=%0d", txn,
                 grant, grant_valid, grant_encoded, credit);
        checks++;
        if (mon_a === mon_e) passes++;
        else $display("FAIL scoreboard txn %0d: got g=%b v=%b e=%0d c=%0d expected g=%b v=%b e=%0d c=%0d",
                      txn, mon_a.g, mon_a.v, mon_a.e, mon_a.c, mon_e.g, mon_e.v, mon_e.e, mon_e.c);
      end
    end
  end

  logic [P*WW-1:0] wt;
  logic [P-1:0]    rq, ug, ak, ls, pend, gm;
  int seq_enc [8] = '{0, 0, 0, 1, 0, 0, 0, 1};
  int seq_cr  [8] = '{3, 2, 1, 1, 3, 2, 1, 1};

  initial begin
    rst = 1'b1; request = '0; urgent = '0; acknowledge = '0; last = '0; weight = '0;
    model_reset();
    #1;
    check("reset_grant", int'(grant), 0);
    check("reset_valid", int'(grant_valid), 0);
    check("reset_enc", int'(grant_encoded), 0);
    check("reset_credit", int'(credit), 0);

    // Two requesters, unit weights: alternate back to back.
    wt = 16'h1111;
    do_reset(wt);
    drive(1'b0, 4'b0101, '0, '0, '0, wt);          expect_now("t1_first", 4'b0001, 1);
    drive(1'b0, 4'b0101, '0, 4'b0001, 4'b0001, wt); expect_now("t1_rot", 4'b0100, 1);
    drive(1'b0, 4'b0101, '0, 4'b0100, 4'b0100, wt); expect_now("t1_wrap", 4'b0001, 1);

    // Weight 3 vs 1 with single-beat bursts.
    wt = 16'h1113;
    do_reset(wt);
    drive(1'b0, 4'b0011, '0, '0, '0, wt);
    expect_now("t2_s0", P'(1) << seq_enc[0], seq_cr[0]);
    for (int k = 1; k < 8; k++) begin
      gm = P'(1) << m_port;
      drive(1'b0, 4'b0011, '0, gm, gm, wt);
      expect_now($sformatf("t2_s%0d", k), P'(1) << seq_enc[k], seq_cr[k]);
    end

    // Urgent pre-emption lands only at the burst boundary.
    wt = 16'h4444;
    do_reset(wt);
    drive(1'b0, 4'b0010, '0, '0, '0, wt);                    expect_now("t3_g1", 4'b0010, 4);
    drive(1'b0, 4'b1010, 4'b1000, 4'b0010, '0, wt);          expect_now("t3_mid", 4'b0010, 4);
    drive(1'b0, 4'b1010, 4'b1000, 4'b0010, '0, wt);          expect_now("t3_mid2", 4'b0010, 4);
    drive(1'b0, 4'b1010, 4'b1000, 4'b0010, 4'b0010, wt);     expect_now("t3_preempt", 4'b1000, 4);
    drive(1'b0, 4'b0000, '0, 4'b1000, 4'b1000, wt);          expect_now("t3_idle", 4'b0000, 0);
    do_reset(wt);
    drive(1'b0, 4'b0010, 4'b0010, '0, '0, wt);               expect_now("t3b_g1", 4'b0010, 4);
    drive(1'b0, 4'b1010, 4'b1010, 4'b0010, 4'b0010, wt);     expect_now("t3b_keep", 4'b0010, 3);
    drive(1'b0, 4'b1000, 4'b1000, 4'b0010, 4'b0010, wt);     expect_now("t3b_next", 4'b1000, 4);

    // Zero weight acts as one; lone requester re-granted without an idle gap.
    wt = 16'h1011;
    do_reset(wt);
    drive(1'b0, 4'b0100, '0, '0, '0, wt);                    expect_now("t4_g", 4'b0100, 1);
    drive(1'b0, 4'b0100, '0, 4'b0100, 4'b0100, wt);          expect_now("t4_re1", 4'b0100, 1);
    drive(1'b0, 4'b0100, '0, 4'b0100, 4'b0100, wt);          expect_now("t4_re2", 4'b0100, 1);
    // Request released on the boundary cycle, then a fresh requester.
    drive(1'b0, 4'b0000, '0, 4'b0100, 4'b0100, wt);          expect_now("t5_idle", 4'b0000, 0);
    check("t5_enc_hold", int'(grant_encoded), 2);
    drive(1'b0, 4'b1000, '0, '0, '0, wt);                    expect_now("t5_p3", 4'b1000, 1);

    // Asynchronous reset between clock edges, mid-burst.
    drive(1'b0, 4'b1000, '0, 4'b1000, '0, wt);
    @(posedge clk); #3;
    rst = 1'b1;
    #1;
    check("t6_async_grant", int'(grant), 0);
    check("t6_async_valid", int'(grant_valid), 0);
    check("t6_async_credit", int'(credit), 0);
    model_reset();
    drive(1'b1, 4'b1111, '0, '0, '0, wt);
    drive(1'b0, 4'b1111, '0, '0, '0, wt);                    expect_now("t6_after", 4'b0001, 1);
    drive(1'b0, 4'b0000, '0, 4'b0001, 4'b0001, wt);

    // Random traffic obeying the hold-until-served request rule.
    do_reset(wt);
    pend = '0;
    for (int cyc = 0; cyc < 400; cyc++) begin
      if (cyc % 60 == 0)
        for (int i = 0; i < P; i++) wt[i*WW +: WW] = WW'($urandom_range(0, 5));
      rq = pend;
      for (int i = 0; i < P; i++)
        if (!rq[i] && $urandom_range(0, 3) == 0) rq[i] = 1'b1;
      ug = rq & P'($urandom) & P'($urandom);
      ak = P'($urandom);
      ls = P'($urandom);
      if (m_valid && ak[m_port] && ls[m_port] && $urandom_range(0, 2) == 0) rq[m_port] = 1'b0;
      pend = rq;
      drive(1'b0, rq, ug, ak, ls, wt);
    end
    drive(1'b0, '0, '0, '1, '1, wt);
    drive(1'b0, '0, '0, '0, '0, wt);

    repeat (3) @(posedge clk);
    #3;
    check("queue_drained", exp_q.size(), 0);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
